inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage feeding the combinational instruction ROM and the decode stage.
//  - Owns the PC and drives a word address to the ROM each cycle.
//  - Captures the returned word with its PC into a small prefetch FIFO.
//  - Presents FIFO entries to decode through a valid/ready handshake.
//  - Decode (or EX) redirects fetch on branches and exceptions; a redirect flushes the FIFO.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  PC loaded on reset (MIPS reset vector)
//  DEPTH     2              prefetch FIFO entries; power of two, >=2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous reset, active-high
//  rom_address     out  32  fetch byte address; ROM indexes address[31:2]
//  rom_data        in   32  ROM word, valid combinationally in the same cycle
//  redirect_valid  in   1   load a new PC and flush the FIFO
//  redirect_pc     in   32  redirect target
//  id_ready        in   1   decode accepts the head entry
//  id_valid        out  1   head entry valid
//  id_inst         out  32  head instruction
//  id_pc           out  32  PC of head instruction
//  fetch_fault     out  1   misaligned redirect latched (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high.
//  - Reset values: pc=RESET_PC, FIFO count=0, rd/wr ptr=0, id_valid=0, id_inst=0, id_pc=0,
//    fetch_fault=0. rom_address=RESET_PC.
//  - rom_address = pc (registered). A reset asserted mid-operation discards all entries.
//  - pop  = id_valid & id_ready
//  - push = !redirect_valid & !halted & (count<DEPTH | pop)
//    push writes {pc, rom_data} at wr_ptr, then pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
//  - When the FIFO is full and pop=0: pc holds and rom_address is stable. No entry is lost or duplicated.
//  - Simultaneous push and pop while full: both occur, count is unchanged.
//  - id_valid = (count!=0). id_inst and id_pc come straight from the FIFO head, a registered-state
//    path with no combinational path from id_ready or redirect_valid.
//  - Redirect (highest priority):
//    - A pop in the same cycle still completes; decode owns the discard.
//    - No push that cycle.
//    - count<=0 and ptrs<=0; pc<=redirect_pc.
//    - Latency: redirect in cycle N -> rom_address=target in N+1 -> id_valid with target in N+2.
//  - Back-to-back redirects: the last one wins. Each redirect restarts the latency.
//  - Empty FIFO with id_ready=1: id_valid=0, no pop.
//  - halted: see CONFIGURATION. It is always 0 when the macro is absent.
// CONFIGURATION
//  Macro FETCH_ALIGN_CHECK_EN:
//  - Defined:
//    - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 and halted=1.
//    - pc<=redirect_pc as-is, and the FIFO is flushed.
//    - No pushes occur while halted.
//    - The next aligned redirect clears fetch_fault and halted.
//    - fetch_fault is sticky until that aligned redirect or rst.
//  - Undefined:
//    - redirect_pc[1:0] is forced to 2'b00 on load.
//    - fetch_fault is tied 0; halted is constant 0.
// TESTING
//  1. Reset, ROM[i]=i, id_ready=1 -> cycle1: id_valid=0; cycle2: id_pc=BFC00000,
//     id_inst=ROM word; then one instruction per cycle, PC +4 each.
//  2. id_ready=0 for 6 cycles -> count saturates at 2, rom_address holds RESET_PC+8;
//     release -> PCs BFC00000, +4, +8 delivered in order, none lost.
//  3. FIFO full, redirect_valid=1 to 0000_0100 with id_ready=1 -> head popped that cycle;
//     next id_valid two cycles later with id_pc=0000_0100; no stale PCs delivered.
//  4. pc=FFFF_FFF8, free-run -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  5. rst pulsed with 2 entries buffered -> next cycle id_valid=0, rom_address=RESET_PC.
//  6. FETCH_ALIGN_CHECK_EN: redirect to 0000_0102 -> fetch_fault=1, id_valid stays 0;
//     redirect to 0000_0200 -> fault clears, id_pc=0000_0200 two cycles later.
//     Without the macro: same first redirect -> id_pc=0000_0100, fetch_fault=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, reads the combinational ROM, buffers {pc, word}
// pairs in a small prefetch FIFO and hands them to decode over valid/ready.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect latches fetch_fault and halts fetch.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      pc_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      pc_mem_r   [DEPTH];
    logic [31:0]      inst_mem_r [DEPTH];

    logic        halted_s;
    logic        pop_s;
    logic        push_s;
    logic [31:0] target_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_r;

    // Sticky misalignment fault; doubles as the halt flag until an aligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r <= (redirect_pc[1:0] != 2'b00);
        end else begin
            fault_r <= fault_r;
        end
    end

    assign halted_s    = fault_r;
    assign fetch_fault = fault_r;
    assign target_s    = redirect_pc;
`else
    assign halted_s    = 1'b0;
    assign fetch_fault = 1'b0;
    assign target_s    = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Handshake decode: a full FIFO may still accept a push when the head leaves.
    always_comb begin
        pop_s  = id_valid & id_ready;
        push_s = ~redirect_valid & ~halted_s & ((count_r < FULL_CNT) | pop_s);
    end

    // PC, FIFO storage, pointers and occupancy; a redirect discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 32'd0;
                inst_mem_r[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            pc_r     <= target_s;
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= pc_r;
                inst_mem_r[wr_ptr_r] <= rom_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1'b1);
                pc_r                 <= pc_r + 32'd4;
            end else begin
                wr_ptr_r <= wr_ptr_r;
                pc_r     <= pc_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rom_address = pc_r;
    assign id_valid    = (count_r != {CNT_W{1'b0}});
    assign id_pc       = pc_mem_r[rd_ptr_r];
    assign id_inst     = inst_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// compared against a queue-level model of the fetch stream.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b0;
    logic [31:0] rom_address, rom_data, id_inst, id_pc;
    logic        id_valid, fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: PCs waiting for decode, next fetch PC, fault/halt state.
    logic [31:0] mq[$];
    logic [31:0] mpc;
    logic        mfault, mhalt;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rom_address(rom_address), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    assign rom_data = rom_word(rom_address);

    // Drive one cycle of inputs (at negedge), advance the model, return at the next negedge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic do_pop;
        rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        do_pop = (mq.size() != 0) && rdy;
        if (r) begin
            mq.delete(); mpc = RESET_PC; mhalt = 1'b0; mfault = 1'b0;
        end else if (rv) begin
            mq.delete();
            if (ALIGN) begin
                mpc = rpc; mfault = (rpc[1:0] != 2'b00); mhalt = mfault;
            end else begin
                mpc = {rpc[31:2], 2'b00};
            end
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (!mhalt && mq.size() < DEPTH) begin
                mq.push_back(mpc); mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", id_valid); else n_pass++;
        n_checks++; if (rom_address !== RESET_PC) $display("FAIL reset_addr got %h want %h", rom_address, RESET_PC); else n_pass++;
        n_checks++; if (id_inst !== 32'd0) $display("FAIL reset_inst got %h want 0", id_inst); else n_pass++;
        n_checks++; if (id_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", id_pc); else n_pass++;
        n_checks++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fetch_fault); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            exp = RESET_PC + 32'(4 * k);
            n_checks++; if (id_valid !== 1'b1) $display("FAIL stream_valid k=%0d got %b want 1", k, id_valid); else n_pass++;
            n_checks++; if (id_pc !== exp) $display("FAIL stream_pc k=%0d got %h want %h", k, id_pc, exp); else n_pass++;
            n_checks++; if (id_inst !== rom_word(exp)) $display("FAIL stream_inst k=%0d got %h want %h", k, id_inst, rom_word(exp)); else n_pass++;
            step(1'b0, 1'b0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++; if (rom_address !== RESET_PC + 32'd8) $display("FAIL stall_addr got %h want %h", rom_address, RESET_PC + 32'd8); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            exp = RESET_PC + 32'(4 * k);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== exp) $display("FAIL stall_drain k=%0d got v=%b pc=%h want v=1 pc=%h", k, id_valid, id_pc, exp); else n_pass++;
            step(1'b0, 1'b0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_redirect_full();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++; if (id_pc !== RESET_PC) $display("FAIL redir_head got %h want %h", id_pc, RESET_PC); else n_pass++;
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL redir_n1_valid got %b want 0", id_valid); else n_pass++;
        n_checks++; if (rom_address !== 32'h0000_0100) $display("FAIL redir_n1_addr got %h want 00000100", rom_address); else n_pass++;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0100) $display("FAIL redir_n2 got v=%b pc=%h want v=1 pc=00000100", id_valid, id_pc); else n_pass++;
        n_checks++; if (id_inst !== 32'h0000_0040) $display("FAIL redir_n2_inst got %h want 00000040", id_inst); else n_pass++;
        step(1'b0, 1'b0, 32'd0, 1'b1);
        n_checks++; if (id_pc !== 32'h0000_0104) $display("FAIL redir_n3 got %h want 00000104", id_pc); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        exp = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (id_valid !== 1'b1 || id_pc !== exp) $display("FAIL wrap k=%0d got v=%b pc=%h want v=1 pc=%h", k, id_valid, id_pc, exp); else n_pass++;
            exp = exp + 32'd4;
            step(1'b0, 1'b0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", id_valid); else n_pass++;
        n_checks++; if (rom_address !== RESET_PC) $display("FAIL rstmid_addr got %h want %h", rom_address, RESET_PC); else n_pass++;
        step(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_align();
        step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        if (ALIGN) begin
            n_checks++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0) $display("FAIL align_fault got f=%b v=%b want f=1 v=0", fetch_fault, id_valid); else n_pass++;
            n_checks++; if (rom_address !== 32'h0000_0102) $display("FAIL align_addr got %h want 00000102", rom_address); else n_pass++;
            step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
            n_checks++; if (fetch_fault !== 1'b0) $display("FAIL align_clear got %b want 0", fetch_fault); else n_pass++;
            step(1'b0, 1'b0, 32'd0, 1'b1);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0200) $display("FAIL align_resume got v=%b pc=%h want v=1 pc=00000200", id_valid, id_pc); else n_pass++;
        end else begin
            n_checks++; if (fetch_fault !== 1'b0) $display("FAIL noalign_fault got %b want 0", fetch_fault); else n_pass++;
            step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
            step(1'b0, 1'b0, 32'd0, 1'b1);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0100) $display("FAIL noalign_pc got v=%b pc=%h want v=1 pc=00000100", id_valid, id_pc); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic        r, rv, rdy;
        logic [31:0] rpc;
        for (int c = 0; c < 600; c++) begin
            n_checks++; if (id_valid !== (mq.size() != 0)) $display("FAIL rand_valid c=%0d got %b want %b", c, id_valid, mq.size() != 0); else n_pass++;
            if (mq.size() != 0) begin
                n_checks++; if (id_pc !== mq[0]) $display("FAIL rand_pc c=%0d got %h want %h", c, id_pc, mq[0]); else n_pass++;
                n_checks++; if (id_inst !== rom_word(mq[0])) $display("FAIL rand_inst c=%0d got %h want %h", c, id_inst, rom_word(mq[0])); else n_pass++;
            end
            n_checks++; if (rom_address !== mpc) $display("FAIL rand_addr c=%0d got %h want %h", c, rom_address, mpc); else n_pass++;
            n_checks++; if (fetch_fault !== mfault) $display("FAIL rand_fault c=%0d got %b want %b", c, fetch_fault, mfault); else n_pass++;
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rpc = $urandom & 32'hFFFF_FFFC;
            endcase
            step(r, rv, rpc, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        test_align();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
